// File: rtl/fadd_issue.sv
// fadd_issue: issue/retire controller wrapped around the stage3 single-precision
// FP adder. It accepts FADD.S/FSUB.S micro-ops, unboxes and conditions the
// operands, resolves the rounding mode and drives the adder. It follows each op
// through the adder's fixed latency and returns NaN-boxed results in order,
// with their rd tag and flags, through a small FIFO. It also keeps the accrued
// fflags.
module fadd_issue #(
    parameter int N     = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_rs1,
    input  logic [63:0]  in_rs2,
    input  logic         in_sub,
    input  logic [2:0]   in_rm,
    input  logic [4:0]   in_rd,
    input  logic [2:0]   fcsr_frm,
    input  logic         flush,
    output logic [N-1:0] fa_a,
    output logic [N-1:0] fa_b,
    output logic [2:0]   fa_frm,
    output logic         fa_valid,
    input  logic [N-1:0] fa_out,
    input  logic         fa_of,
    input  logic         fa_uf,
    input  logic         fa_nx,
    input  logic         fa_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [4:0]   out_rd,
    output logic [4:0]   out_fflags,
    output logic         out_illegal,
    output logic [4:0]   fflags_acc,
    input  logic         fflags_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A single-precision value is legal only when NaN-boxed in the 64-bit
    // register. Any other pattern reads as the canonical quiet NaN.
    function automatic logic [31:0] unbox_f(input logic [63:0] v);
        logic [31:0] r;
        if (v[63:32] == 32'hffff_ffff) begin
            r = v[31:0];
        end else begin
            r = 32'h7fc0_0000;
        end
        return r;
    endfunction

    // rm field 3'b111 selects the dynamic rounding mode from fcsr.
    function automatic logic [2:0] resolve_rm_f(input logic [2:0] rm, input logic [2:0] frm);
        logic [2:0] r;
        if (rm == 3'b111) begin
            r = frm;
        end else begin
            r = rm;
        end
        return r;
    endfunction

    // Encodings 101, 110 and 111 are reserved once resolved.
    function automatic logic rm_reserved_f(input logic [2:0] rm);
        logic r;
        case (rm)
            3'b101, 3'b110, 3'b111: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Circular pointer increment that also works for a DEPTH that is not a power of two.
    function automatic logic [PW-1:0] ptr_inc_f(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]    rm_s;
    logic          illegal_s;
    logic [31:0]   op_a_s;
    logic [31:0]   op_b_s;
    logic          accept_s;
    logic          pop_s;
    logic          push_s;
    logic [63:0]   push_data_s;
    logic [4:0]    push_ff_s;

    logic [CW-1:0] occ_r;
    logic [CW-1:0] occ_nxt_s;

    logic          trk_vld_r [0:LAT];
    logic [4:0]    trk_rd_r  [0:LAT];
    logic          trk_ill_r [0:LAT];

    logic [63:0]   fifo_data_r [0:DEPTH-1];
    logic [4:0]    fifo_rd_r   [0:DEPTH-1];
    logic [4:0]    fifo_ff_r   [0:DEPTH-1];
    logic          fifo_ill_r  [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;

    // ------------------------------------------------------------------
    // Handshake and credit
    // ------------------------------------------------------------------

    // Every accepted op holds a credit until it is popped, so the FIFO can never
    // overflow whatever the state of out_ready.
    assign in_ready = (occ_r < CW'(DEPTH)) && !flush && rst_n;
    assign accept_s = in_valid && in_ready;
    assign pop_s    = out_valid && out_ready;

    // Operand conditioning: unbox, flip the sign of b for FSUB, resolve the rounding mode.
    always_comb begin
        op_a_s    = unbox_f(in_rs1);
        op_b_s    = unbox_f(in_rs2);
        rm_s      = resolve_rm_f(in_rm, fcsr_frm);
        illegal_s = rm_reserved_f(rm_s);
        if (in_sub) begin
            op_b_s = {~op_b_s[31], op_b_s[30:0]};
        end else begin
            op_b_s = op_b_s;
        end
    end

    // Next occupancy: flush empties it, and accept with pop in the same cycle cancel out.
    always_comb begin
        occ_nxt_s = occ_r;
        if (flush) begin
            occ_nxt_s = {CW{1'b0}};
        end else if (accept_s && !pop_s) begin
            occ_nxt_s = occ_r + CW'(1);
        end else if (!accept_s && pop_s) begin
            occ_nxt_s = occ_r - CW'(1);
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_r <= {CW{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Adder operand register
    // ------------------------------------------------------------------

    // Launches legal ops into the adder. An illegal op never reaches it but is still tracked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa_a     <= {N{1'b0}};
            fa_b     <= {N{1'b0}};
            fa_frm   <= 3'b000;
            fa_valid <= 1'b0;
        end else if (accept_s && !illegal_s) begin
            fa_a     <= N'(op_a_s);
            fa_b     <= N'(op_b_s);
            fa_frm   <= rm_s;
            fa_valid <= 1'b1;
        end else begin
            fa_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker
    // ------------------------------------------------------------------

    // Stage 0 lines up with fa_valid and stage LAT lines up with fa_out. Illegal
    // ops take the same path so that ordering is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                trk_vld_r[k] <= 1'b0;
                trk_rd_r[k]  <= 5'd0;
                trk_ill_r[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k <= LAT; k++) begin
                trk_vld_r[k] <= 1'b0;
            end
        end else begin
            trk_vld_r[0] <= accept_s;
            trk_rd_r[0]  <= in_rd;
            trk_ill_r[0] <= illegal_s;
            for (int k = 1; k <= LAT; k++) begin
                trk_vld_r[k] <= trk_vld_r[k-1];
                trk_rd_r[k]  <= trk_rd_r[k-1];
                trk_ill_r[k] <= trk_ill_r[k-1];
            end
        end
    end

    // Result entry built from the adder output for the op leaving the last tracker stage.
    always_comb begin
        push_s = trk_vld_r[LAT];
        if (trk_ill_r[LAT]) begin
            push_data_s = 64'd0;
            push_ff_s   = 5'b00000;
        end else begin
            push_data_s = {32'hffff_ffff, fa_out[31:0]};
            push_ff_s   = {fa_inv, 1'b0, fa_of, fa_uf, fa_nx};
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------

    // In-order result buffer. The storage is cleared on reset so that the head reads as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                fifo_data_r[k] <= 64'd0;
                fifo_rd_r[k]   <= 5'd0;
                fifo_ff_r[k]   <= 5'd0;
                fifo_ill_r[k]  <= 1'b0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= push_data_s;
                fifo_rd_r[wr_ptr_r]   <= trk_rd_r[LAT];
                fifo_ff_r[wr_ptr_r]   <= push_ff_s;
                fifo_ill_r[wr_ptr_r]  <= trk_ill_r[LAT];
                wr_ptr_r              <= ptr_inc_f(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc_f(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // The head entry is read straight from storage registers, so it stays stable while stalled.
    assign out_valid   = (cnt_r != {CW{1'b0}});
    assign out_data    = fifo_data_r[rd_ptr_r];
    assign out_rd      = fifo_rd_r[rd_ptr_r];
    assign out_fflags  = fifo_ff_r[rd_ptr_r];
    assign out_illegal = fifo_ill_r[rd_ptr_r];

    // ------------------------------------------------------------------
    // Accrued exception flags
    // ------------------------------------------------------------------

    // Sticky OR of popped flags. A clear in the same cycle as a pop keeps only the popped flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fflags_acc <= 5'b00000;
        end else if (pop_s) begin
            if (fflags_clr) begin
                fflags_acc <= out_fflags;
            end else begin
                fflags_acc <= fflags_acc | out_fflags;
            end
        end else if (fflags_clr) begin
            fflags_acc <= 5'b00000;
        end else begin
            fflags_acc <= fflags_acc;
        end
    end

endmodule

// File: tb/tb_fadd_issue.sv
// Testbench for fadd_issue. The bench acts as the LAT-cycle adder with a
// simple stand-in function that has exact entries for the directed cases, and
// it keeps a queue-based reference model of the retire stream.
module tb_fadd_issue;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic        in_sub;
    logic [2:0]  in_rm;
    logic [4:0]  in_rd;
    logic [2:0]  fcsr_frm;
    logic        flush;
    logic [31:0] fa_a;
    logic [31:0] fa_b;
    logic [2:0]  fa_frm;
    logic        fa_valid;
    logic [31:0] fa_out;
    logic        fa_of;
    logic        fa_uf;
    logic        fa_nx;
    logic        fa_inv;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [4:0]  out_fflags;
    logic        out_illegal;
    logic [4:0]  fflags_acc;
    logic        fflags_clr;

    fadd_issue #(.N(32), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_sub(in_sub), .in_rm(in_rm), .in_rd(in_rd),
        .fcsr_frm(fcsr_frm), .flush(flush),
        .fa_a(fa_a), .fa_b(fa_b), .fa_frm(fa_frm), .fa_valid(fa_valid),
        .fa_out(fa_out), .fa_of(fa_of), .fa_uf(fa_uf), .fa_nx(fa_nx), .fa_inv(fa_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_fflags(out_fflags), .out_illegal(out_illegal),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder: returns {inv, of, uf, nx, result}.
    function automatic logic [35:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] frm);
        logic [31:0] r;
        if (a == 32'h7fc00000 || b == 32'h7fc00000) return {4'b0000, 32'h7fc00000};
        if (a == 32'h3f800000 && b == 32'h40000000) return {4'b0000, 32'h40400000};
        if (a == 32'h40400000 && b == 32'hbf800000) return {4'b0000, 32'h40000000};
        if (a == 32'h7f800000 && b == 32'hff800000) return {4'b1000, 32'h7fc00000};
        if (a == 32'h3f800001 && b == 32'h3f800000) return {4'b0001, 32'h40000000};
        r = a + b + {29'd0, frm};
        return {r[7], r[5], r[3], r[1], r};
    endfunction

    function automatic logic [63:0] boxf(input logic [31:0] x);
        return {32'hffffffff, x};
    endfunction

    // Adder environment: a fixed LAT-cycle pipe that produces garbage when it is not fed.
    logic [35:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (fa_valid) pipe[0] <= fake_add(fa_a, fa_b, fa_frm);
        else          pipe[0] <= {4'($urandom_range(15)), 32'($urandom)};
    end
    assign fa_out = pipe[LAT-1][31:0];
    assign {fa_inv, fa_of, fa_uf, fa_nx} = pipe[LAT-1][35:32];

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [4:0]  ff;
        logic        ill;
        int          app;   // edge after which the entry is visible at the output
    } ent_t;

    ent_t        q[$];
    int          edges_done;
    logic        fa_valid_m;
    logic [31:0] fa_a_m, fa_b_m;
    logic [2:0]  fa_frm_m;
    logic [4:0]  acc_m;

    int   n_cmp;
    int   n_bad;
    logic last_acc;
    int   ov_seen;
    logic [4:0] popq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: check the DUT against the model, advance the model over the next edge, then wait.
    task automatic step();
        logic exp_ir, exp_ov, acc, pop;
        logic [31:0] a, b;
        logic [2:0] rm;
        logic [35:0] r;
        ent_t e;
        #1;
        exp_ir = rst_n && !flush && (q.size() < DEPTH);
        exp_ov = (q.size() > 0) && (q[0].app <= edges_done);
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_data", out_data, q[0].data);
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
            chk("out_fflags", 64'(out_fflags), 64'(q[0].ff));
            chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
        end
        chk("fa_valid", 64'(fa_valid), 64'(fa_valid_m));
        if (fa_valid_m) begin
            chk("fa_a", 64'(fa_a), 64'(fa_a_m));
            chk("fa_b", 64'(fa_b), 64'(fa_b_m));
            chk("fa_frm", 64'(fa_frm), 64'(fa_frm_m));
        end
        chk("fflags_acc", 64'(fflags_acc), 64'(acc_m));
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) popq.push_back(out_rd);
        if (out_valid) ov_seen++;

        if (!rst_n) begin
            q.delete();
            fa_valid_m = 1'b0;
            acc_m = 5'd0;
        end else begin
            pop = exp_ov && out_ready;
            acc = in_valid && exp_ir;
            if (pop) begin
                acc_m = fflags_clr ? q[0].ff : (acc_m | q[0].ff);
                void'(q.pop_front());
            end else if (fflags_clr) begin
                acc_m = 5'd0;
            end
            fa_valid_m = 1'b0;
            if (acc) begin
                a  = (in_rs1[63:32] == 32'hffffffff) ? in_rs1[31:0] : 32'h7fc00000;
                b  = (in_rs2[63:32] == 32'hffffffff) ? in_rs2[31:0] : 32'h7fc00000;
                if (in_sub) b[31] = ~b[31];
                rm = (in_rm == 3'd7) ? fcsr_frm : in_rm;
                e.ill = (rm >= 3'd5);
                r = fake_add(a, b, rm);
                e.data = e.ill ? 64'd0 : {32'hffffffff, r[31:0]};
                e.ff   = e.ill ? 5'd0 : {r[35], 1'b0, r[34], r[33], r[32]};
                e.rd   = in_rd;
                e.app  = edges_done + LAT + 2;
                q.push_back(e);
                if (!e.ill) begin
                    fa_valid_m = 1'b1;
                    fa_a_m = a;
                    fa_b_m = b;
                    fa_frm_m = rm;
                end
            end
            if (flush) q.delete();
        end
        edges_done++;
        @(negedge clk);
    endtask

    task automatic set_op(input logic [63:0] r1, input logic [63:0] r2, input logic sb,
                          input logic [2:0] rm, input logic [4:0] rd);
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_sub = sb; in_rm = rm; in_rd = rd;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; fflags_clr = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int idx;
        n_cmp = 0; n_bad = 0; ov_seen = 0; edges_done = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = 64'd0; in_rs2 = 64'd0; in_sub = 1'b0;
        in_rm = 3'd0; in_rd = 5'd0; fcsr_frm = 3'd0; flush = 1'b0; out_ready = 1'b1;
        fflags_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_fflags", 64'(out_fflags), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_fa_valid", 64'(fa_valid), 64'd0);
        chk("rst_fa_a", 64'(fa_a), 64'd0);
        chk("rst_fa_b", 64'(fa_b), 64'd0);
        chk("rst_fa_frm", 64'(fa_frm), 64'd0);
        chk("rst_fflags_acc", 64'(fflags_acc), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        q.delete(); fa_valid_m = 1'b0; acc_m = 5'd0; fa_a_m = 32'd0; fa_b_m = 32'd0; fa_frm_m = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 2.0
        set_op(boxf(32'h3f800000), boxf(32'h40000000), 1'b0, 3'd0, 5'd3);
        step(); in_valid = 1'b0;
        chk("t1_fa_valid", 64'(fa_valid), 64'd1);
        chk("t1_fa_a", 64'(fa_a), 64'h3f800000);
        chk("t1_fa_b", 64'(fa_b), 64'h40000000);
        repeat (2) step();
        chk("t1_no_early_out", 64'(out_valid), 64'd0);
        step();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", out_data, 64'hffffffff40400000);
        chk("t1_out_rd", 64'(out_rd), 64'd3);
        chk("t1_out_fflags", 64'(out_fflags), 64'd0);
        drain();

        // FSUB with dynamic rounding mode
        fcsr_frm = 3'b001;
        set_op(boxf(32'h40400000), boxf(32'h3f800000), 1'b1, 3'b111, 5'd4);
        step(); in_valid = 1'b0;
        chk("t2_fa_b", 64'(fa_b), 64'hbf800000);
        chk("t2_fa_frm", 64'(fa_frm), 64'd1);
        repeat (3) step();
        chk("t2_out_data", out_data, 64'hffffffff40000000);
        drain();

        // unboxed operand
        set_op({32'h00000000, 32'h3f800000}, boxf(32'h3f800000), 1'b0, 3'd0, 5'd5);
        step(); in_valid = 1'b0;
        chk("t3_fa_a", 64'(fa_a), 64'h7fc00000);
        repeat (3) step();
        chk("t3_out_data", out_data, 64'hffffffff7fc00000);
        drain();

        // legal op followed by a reserved rounding mode
        set_op(boxf(32'h3f800000), boxf(32'h40000000), 1'b0, 3'd0, 5'd6);
        step();
        set_op(boxf(32'h3f800000), boxf(32'h40000000), 1'b0, 3'b101, 5'd7);
        step(); in_valid = 1'b0;
        chk("t4_no_fa_valid", 64'(fa_valid), 64'd0);
        repeat (2) step();
        chk("t4_first_rd", 64'(out_rd), 64'd6);
        chk("t4_first_ill", 64'(out_illegal), 64'd0);
        step();
        chk("t4_second_valid", 64'(out_valid), 64'd1);
        chk("t4_second_rd", 64'(out_rd), 64'd7);
        chk("t4_second_ill", 64'(out_illegal), 64'd1);
        chk("t4_second_data", out_data, 64'd0);
        drain();

        // back-pressure: 6 offered, 4 accepted
        out_ready = 1'b0; idx = 0; popq.delete();
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) set_op(boxf(32'($urandom)), boxf(32'($urandom)), 1'b0, 3'd0, 5'(10 + idx));
            else in_valid = 1'b0;
            step();
            if (last_acc) idx++;
        end
        chk("t5_accepted", 64'(idx), 64'd4);
        chk("t5_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (idx < 6) set_op(boxf(32'($urandom)), boxf(32'($urandom)), 1'b0, 3'd0, 5'(10 + idx));
            else in_valid = 1'b0;
            step();
            if (last_acc) idx++;
        end
        chk("t5_all_accepted", 64'(idx), 64'd6);
        chk("t5_pop_count", 64'(popq.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < popq.size()) chk("t5_pop_order", 64'(popq[k]), 64'(10 + k));
        end
        drain();

        // flags: clear alone, invalid op, clear coinciding with a pop
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        chk("t6_clr_alone", 64'(fflags_acc), 64'd0);
        set_op(boxf(32'h7f800000), boxf(32'hff800000), 1'b0, 3'd0, 5'd8);
        step(); in_valid = 1'b0;
        repeat (3) step();
        chk("t6_inf_data", out_data, 64'hffffffff7fc00000);
        chk("t6_inf_fflags", 64'(out_fflags), 64'b10000);
        step();
        chk("t6_acc_nv", 64'(fflags_acc), 64'b10000);
        set_op(boxf(32'h3f800001), boxf(32'h3f800000), 1'b0, 3'd0, 5'd9);
        step(); in_valid = 1'b0;
        repeat (3) step();
        fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
        chk("t6_acc_clr_pop", 64'(fflags_acc), 64'b00001);
        drain();

        // flush with two ops in flight
        set_op(boxf(32'h3f800000), boxf(32'h40000000), 1'b0, 3'd0, 5'd20);
        step();
        set_op(boxf(32'h40400000), boxf(32'h40000000), 1'b0, 3'd0, 5'd21);
        step();
        set_op(boxf(32'h3f800000), boxf(32'h3f800000), 1'b0, 3'd0, 5'd22);
        flush = 1'b1;
        #1;
        chk("t7_flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t7_ready_after", 64'(in_ready), 64'd1);
        ov_seen = 0;
        repeat (8) step();
        chk("t7_no_out_valid", 64'(ov_seen), 64'd0);
        chk("t7_acc_kept", 64'(fflags_acc), 64'b00001);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(255) != 0);
            flush      = ($urandom_range(39) == 0);
            fflags_clr = ($urandom_range(15) == 0);
            out_ready  = ($urandom_range(9) < 7);
            fcsr_frm   = 3'($urandom_range(7));
            in_valid   = ($urandom_range(9) < 7);
            in_rs1     = ($urandom_range(7) != 0) ? boxf(32'($urandom)) : {32'($urandom), 32'($urandom)};
            in_rs2     = ($urandom_range(7) != 0) ? boxf(32'($urandom)) : {32'($urandom), 32'($urandom)};
            in_sub     = 1'($urandom_range(1));
            in_rm      = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(4));
            in_rd      = 5'($urandom_range(31));
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
